// File: rtl/fifo_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read mode, programmable
// almost-full/almost-empty flags, synchronous flush and overflow/underflow pulses.

module BiMemTp #(
  parameter        PROFILE = "FFdefault",
  parameter int    WIDTH   = 16,
  parameter int    DEPTH   = 4,
  parameter int    AW      = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic             rd_clr_i,
  output logic [WIDTH-1:0] rd_data_o
);
  // The default profile returns old data on an address collision; others forward the write.
  localparam bit WRITE_FIRST = (PROFILE != "FFdefault");

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_word_s;
  logic [WIDTH-1:0] rd_data_q;

  always_comb begin
    rd_word_s = mem_q[rd_addr_i];
    if (WRITE_FIRST && wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_word_s = wr_data_i;
    end else begin
      rd_word_s = mem_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_clr_i) begin
      rd_data_q <= {WIDTH{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= rd_word_s;
    end
  end

  assign rd_data_o = rd_data_q;
endmodule

module fifo_flex #(
  parameter        PROFILE    = "FFdefault",
  parameter int    WIDTH      = 16,
  parameter int    LENGTH     = 4,
  parameter int    FWFT       = 0,
  parameter int    AFULL_THR  = 1,
  parameter int    AEMPTY_THR = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [WIDTH-1:0]          writeData_i,
  input  logic                      writeEnable_i,
  output logic                      writeBusy_o,
  output logic [WIDTH-1:0]          readData_o,
  input  logic                      readEnable_i,
  output logic                      readBusy_o,
  output logic [$clog2(LENGTH):0]   space_o,
  output logic [$clog2(LENGTH):0]   avail_o,
  output logic                      almostFull_o,
  output logic                      almostEmpty_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);
  localparam int            AW        = $clog2(LENGTH);
  localparam int            CW        = AW + 1;
  localparam bit            FWFT_MODE = (FWFT != 0);
  localparam logic [AW-1:0] LAST_ADDR = AW'(LENGTH - 1);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LEN   = CW'(LENGTH);
  localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_THR);
  localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_THR);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] avail_q, avail_d, space_q, space_d;
  logic [CW-1:0] mem_cnt_q, mem_cnt_d;
  logic          head_valid_q, head_valid_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic          write_busy_s, read_busy_s, wr_acc_s, rd_acc_s, mem_rd_s;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
    if (ptr == LAST_ADDR) begin
      return ADDR_ZERO;
    end else begin
      return ptr + AW'(1);
    end
  endfunction

  // In FWFT mode the memory's registered read port is the prefetch stage: the head item
  // lives there, and a new fetch is issued whenever it is empty or being popped.
  assign write_busy_s = (space_q == CNT_ZERO);
  assign read_busy_s  = FWFT_MODE ? ~head_valid_q : (avail_q == CNT_ZERO);
  assign wr_acc_s     = writeEnable_i & ~write_busy_s & ~flush_i;
  assign rd_acc_s     = readEnable_i & ~read_busy_s & ~flush_i;
  assign mem_rd_s     = FWFT_MODE ? ((mem_cnt_q != CNT_ZERO) & (~head_valid_q | rd_acc_s) & ~flush_i)
                                  : rd_acc_s;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    avail_d      = avail_q;
    space_d      = space_q;
    mem_cnt_d    = mem_cnt_q;
    head_valid_d = head_valid_q;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    if (flush_i) begin
      wr_ptr_d     = ADDR_ZERO;
      rd_ptr_d     = ADDR_ZERO;
      avail_d      = CNT_ZERO;
      space_d      = CNT_LEN;
      mem_cnt_d    = CNT_ZERO;
      head_valid_d = 1'b0;
    end else begin
      overflow_d  = writeEnable_i & write_busy_s;
      underflow_d = readEnable_i & read_busy_s;
      if (wr_acc_s) begin
        wr_ptr_d = ptr_next(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (mem_rd_s) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   begin avail_d = avail_q + CNT_ONE; space_d = space_q - CNT_ONE; end
        2'b01:   begin avail_d = avail_q - CNT_ONE; space_d = space_q + CNT_ONE; end
        default: begin avail_d = avail_q;           space_d = space_q;           end
      endcase
      case ({wr_acc_s, mem_rd_s})
        2'b10:   mem_cnt_d = mem_cnt_q + CNT_ONE;
        2'b01:   mem_cnt_d = mem_cnt_q - CNT_ONE;
        default: mem_cnt_d = mem_cnt_q;
      endcase
      if (mem_rd_s) begin
        head_valid_d = 1'b1;
      end else if (rd_acc_s) begin
        head_valid_d = 1'b0;
      end else begin
        head_valid_d = head_valid_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= ADDR_ZERO;
      rd_ptr_q     <= ADDR_ZERO;
      avail_q      <= CNT_ZERO;
      space_q      <= CNT_LEN;
      mem_cnt_q    <= CNT_ZERO;
      head_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      avail_q      <= avail_d;
      space_q      <= space_d;
      mem_cnt_q    <= mem_cnt_d;
      head_valid_q <= head_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  BiMemTp #(
    .PROFILE (PROFILE),
    .WIDTH   (WIDTH),
    .DEPTH   (LENGTH),
    .AW      (AW)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (wr_acc_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (writeData_i),
    .rd_en_i   (mem_rd_s),
    .rd_addr_i (rd_ptr_q),
    .rd_clr_i  (rst_i | flush_i),
    .rd_data_o (readData_o)
  );

  assign writeBusy_o   = write_busy_s;
  assign readBusy_o    = read_busy_s;
  assign space_o       = space_q;
  assign avail_o       = avail_q;
  assign almostFull_o  = (space_q <= AFULL_C);
  assign almostEmpty_o = (avail_q <= AEMPTY_C);
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;
endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench: instance a (LENGTH=5, standard), b (LENGTH=4, FWFT), c (LENGTH=8, thresholds 2/1).

module tb_fifo_flex;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, flush_a, we_a, re_a, wbusy_a, rbusy_a, af_a, ae_a, ov_a, un_a;
  logic [15:0] wd_a, rd_a;
  logic [3:0]  space_a, avail_a;
  logic        rst_b, flush_b, we_b, re_b, wbusy_b, rbusy_b, af_b, ae_b, ov_b, un_b;
  logic [15:0] wd_b, rd_b;
  logic [2:0]  space_b, avail_b;
  logic        rst_c, flush_c, we_c, re_c, wbusy_c, rbusy_c, af_c, ae_c, ov_c, un_c;
  logic [15:0] wd_c, rd_c;
  logic [3:0]  space_c, avail_c;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic        pend_a = 1'b0;

  fifo_flex #(.WIDTH(16), .LENGTH(5), .FWFT(0), .AFULL_THR(1), .AEMPTY_THR(1)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .flush_i(flush_a), .writeData_i(wd_a), .writeEnable_i(we_a),
    .writeBusy_o(wbusy_a), .readData_o(rd_a), .readEnable_i(re_a), .readBusy_o(rbusy_a),
    .space_o(space_a), .avail_o(avail_a), .almostFull_o(af_a), .almostEmpty_o(ae_a),
    .overflow_o(ov_a), .underflow_o(un_a));

  fifo_flex #(.WIDTH(16), .LENGTH(4), .FWFT(1), .AFULL_THR(1), .AEMPTY_THR(1)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .flush_i(flush_b), .writeData_i(wd_b), .writeEnable_i(we_b),
    .writeBusy_o(wbusy_b), .readData_o(rd_b), .readEnable_i(re_b), .readBusy_o(rbusy_b),
    .space_o(space_b), .avail_o(avail_b), .almostFull_o(af_b), .almostEmpty_o(ae_b),
    .overflow_o(ov_b), .underflow_o(un_b));

  fifo_flex #(.WIDTH(16), .LENGTH(8), .FWFT(0), .AFULL_THR(2), .AEMPTY_THR(1)) dut_c (
    .clk_i(clk), .rst_i(rst_c), .flush_i(flush_c), .writeData_i(wd_c), .writeEnable_i(we_c),
    .writeBusy_o(wbusy_c), .readData_o(rd_c), .readEnable_i(re_c), .readBusy_o(rbusy_c),
    .space_o(space_c), .avail_o(avail_c), .almostFull_o(af_c), .almostEmpty_o(ae_c),
    .overflow_o(ov_c), .underflow_o(un_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Standard mode: data is due the cycle after an accepted read
  always @(negedge clk) begin
    if (pend_a) begin
      if (exp_a.size() == 0) check("a_unexpected_data", 32'd1, 32'd0);
      else check("a_read_data", 32'(rd_a), 32'(exp_a.pop_front()));
    end
    pend_a <= re_a && !rbusy_a && !rst_a && !flush_a;
  end

  // FWFT mode: the head item is on readData_o in the popping cycle
  always @(negedge clk) begin
    if (re_b && !rbusy_b && !rst_b && !flush_b) begin
      if (exp_b.size() == 0) check("b_unexpected_data", 32'd1, 32'd0);
      else check("b_read_data", 32'(rd_b), 32'(exp_b.pop_front()));
    end
  end

  initial begin
    {rst_a, rst_b, rst_c} = 3'b111;
    {flush_a, flush_b, flush_c, we_a, we_b, we_c, re_a, re_b, re_c} = 9'd0;
    wd_a = 16'h0000; wd_b = 16'h0000; wd_c = 16'h0000;
    tick; tick;
    {rst_a, rst_b, rst_c} = 3'b000;

    check("a_rst_avail", 32'(avail_a), 32'd0);
    check("a_rst_space", 32'(space_a), 32'd5);
    check("a_rst_rbusy", 32'(rbusy_a), 32'd1);
    check("a_rst_wbusy", 32'(wbusy_a), 32'd0);
    check("a_rst_ae", 32'(ae_a), 32'd1);
    check("a_rst_af", 32'(af_a), 32'd0);
    check("a_rst_ov_un", 32'({ov_a, un_a}), 32'd0);
    check("b_rst_data", 32'(rd_b), 32'd0);
    check("b_rst_rbusy", 32'(rbusy_b), 32'd1);
    check("b_rst_space", 32'(space_b), 32'd4);

    // Fill A, then attempt one write too many
    for (int i = 0; i < 5; i++) begin
      we_a = 1'b1; wd_a = 16'(16'hA0 + i); exp_a.push_back(wd_a); tick;
    end
    we_a = 1'b0;
    check("a_full_wbusy", 32'(wbusy_a), 32'd1);
    check("a_full_space", 32'(space_a), 32'd0);
    check("a_full_af", 32'(af_a), 32'd1);
    check("a_full_ae", 32'(ae_a), 32'd0);
    we_a = 1'b1; wd_a = 16'h00EE; tick; we_a = 1'b0;
    check("a_overflow_pulse", 32'(ov_a), 32'd1);
    check("a_overflow_avail", 32'(avail_a), 32'd5);
    tick;
    check("a_overflow_clears", 32'(ov_a), 32'd0);

    re_a = 1'b1; repeat (3) tick; re_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      we_a = 1'b1; wd_a = 16'(16'hB0 + i); exp_a.push_back(wd_a); tick;
    end
    we_a = 1'b0;
    check("a_wrap_avail", 32'(avail_a), 32'd5);
    re_a = 1'b1; repeat (5) tick; re_a = 1'b0;
    check("a_empty_avail", 32'(avail_a), 32'd0);
    check("a_empty_rbusy", 32'(rbusy_a), 32'd1);
    re_a = 1'b1; tick; re_a = 1'b0;
    check("a_underflow_pulse", 32'(un_a), 32'd1);
    check("a_data_hold", 32'(rd_a), 32'hB2);
    tick;
    check("a_underflow_clears", 32'(un_a), 32'd0);
    check("a_drained", 32'(exp_a.size()), 32'd0);

    // Simultaneous read and write with two items held
    for (int i = 0; i < 2; i++) begin
      we_a = 1'b1; wd_a = 16'(16'hC0 + i); exp_a.push_back(wd_a); tick;
    end
    for (int i = 0; i < 10; i++) begin
      we_a = 1'b1; re_a = 1'b1; wd_a = 16'(16'hC2 + i); exp_a.push_back(wd_a); tick;
      check("a_simul_avail", 32'(avail_a), 32'd2);
    end
    we_a = 1'b0; re_a = 1'b1; tick; tick; re_a = 1'b0; tick;
    check("a_simul_drained", 32'(exp_a.size()), 32'd0);
    we_a = 1'b1; re_a = 1'b1; wd_a = 16'h00D0; exp_a.push_back(wd_a); tick;
    we_a = 1'b0; re_a = 1'b0;
    check("a_empty_rw_underflow", 32'(un_a), 32'd1);
    check("a_empty_rw_avail", 32'(avail_a), 32'd1);
    re_a = 1'b1; tick; re_a = 1'b0; tick;

    // Flush with a concurrent write, then reset during a read burst
    for (int i = 0; i < 3; i++) begin
      we_a = 1'b1; wd_a = 16'(16'hE0 + i); exp_a.push_back(wd_a); tick;
    end
    flush_a = 1'b1; wd_a = 16'h00FF; tick;
    flush_a = 1'b0; we_a = 1'b0; exp_a.delete();
    check("a_flush_avail", 32'(avail_a), 32'd0);
    check("a_flush_space", 32'(space_a), 32'd5);
    check("a_flush_rbusy", 32'(rbusy_a), 32'd1);
    check("a_flush_no_err", 32'({ov_a, un_a}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      we_a = 1'b1; wd_a = 16'(16'hF0 + i); exp_a.push_back(wd_a); tick;
    end
    we_a = 1'b0; re_a = 1'b1; tick; tick;
    rst_a = 1'b1; tick;
    rst_a = 1'b0; re_a = 1'b0; exp_a.delete();
    check("a_rst2_avail", 32'(avail_a), 32'd0);
    check("a_rst2_space", 32'(space_a), 32'd5);
    check("a_rst2_flags", 32'({rbusy_a, wbusy_a, ae_a, af_a}), 32'b1010);

    // FWFT latency: write in cycle N is presentable in cycle N+2
    we_b = 1'b1; wd_b = 16'h0011; exp_b.push_back(wd_b); tick; we_b = 1'b0;
    check("b_window_rbusy", 32'(rbusy_b), 32'd1);
    check("b_window_avail", 32'(avail_b), 32'd1);
    tick;
    check("b_n2_rbusy", 32'(rbusy_b), 32'd0);
    check("b_n2_data", 32'(rd_b), 32'h11);
    re_b = 1'b1; tick; re_b = 1'b0;
    check("b_pop_rbusy", 32'(rbusy_b), 32'd1);
    check("b_pop_hold", 32'(rd_b), 32'h11);
    for (int i = 0; i < 4; i++) begin
      we_b = 1'b1; wd_b = 16'(16'h21 + i); exp_b.push_back(wd_b); tick;
    end
    we_b = 1'b0;
    check("b_full_wbusy", 32'(wbusy_b), 32'd1);
    check("b_full_avail", 32'(avail_b), 32'd4);
    re_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("b_no_bubble", 32'(rbusy_b), 32'd0);
      tick;
    end
    re_b = 1'b0;
    check("b_burst_rbusy", 32'(rbusy_b), 32'd1);
    check("b_burst_avail", 32'(avail_b), 32'd0);
    we_b = 1'b1; re_b = 1'b1; wd_b = 16'h0031; exp_b.push_back(wd_b); tick;
    we_b = 1'b0; re_b = 1'b0;
    check("b_empty_rw_underflow", 32'(un_b), 32'd1);
    check("b_empty_rw_avail", 32'(avail_b), 32'd1);
    tick;
    re_b = 1'b1; tick; re_b = 1'b0;
    we_b = 1'b1; wd_b = 16'h0041; tick; wd_b = 16'h0042; tick; we_b = 1'b0; tick;
    flush_b = 1'b1; tick; flush_b = 1'b0;
    check("b_flush_data", 32'(rd_b), 32'd0);
    check("b_flush_rbusy", 32'(rbusy_b), 32'd1);
    check("b_flush_avail", 32'(avail_b), 32'd0);
    check("b_flush_flags", 32'({ov_b, un_b, ae_b, af_b}), 32'b0010);

    // Threshold flags, one item at a time
    check("c_rst_flags", 32'({ae_c, af_c}), 32'b10);
    for (int k = 1; k <= 8; k++) begin
      we_c = 1'b1; wd_c = 16'(k); tick;
      check("c_avail", 32'(avail_c), 32'(k));
      check("c_almost_empty", 32'(ae_c), 32'(k <= 1));
      check("c_almost_full", 32'(af_c), 32'(k >= 6));
    end
    we_c = 1'b0;
    check("c_full", 32'({wbusy_c, rbusy_c, space_c}), 32'({1'b1, 1'b0, 4'd0}));
    re_c = 1'b1; tick; re_c = 1'b0; tick;
    check("c_first_data", 32'(rd_c), 32'd1);
    check("c_no_err", 32'({ov_c, un_c, wbusy_c}), 32'd0);

    check("a_scoreboard_empty", 32'(exp_a.size()), 32'd0);
    check("b_scoreboard_empty", 32'(exp_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
